// File: rtl/cv32e40p_mult_voter_ft.sv
// cv32e40p_mult_voter_ft
// This block votes on the results of three replicated MULT units for a single
// multiply and returns one result. It also drives the per-replica error pulses
// that the MULT error counters consume.
// A replica that is permanently faulty for the operator's class gets no vote.
// A replica that never returns a result is caught by a COLLECT timeout.
// Optional feature: define MULT_VOTER_STATS_EN to build a saturating counter of
// no-majority votes on vote_fail_cnt_o. Otherwise that output is tied to 0.
// Timing: error_detected_o and mult_operator_o pulse for exactly one cycle. That
// cycle is the register stage of the VOTE compare, which is also the first cycle
// of valid_o.

module cv32e40p_mult_voter_ft #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       mult_operator_i,
  input  logic [2:0]       mult_valid_i,
  input  logic [2:0][31:0] mult_result_i,
  input  logic [2:0][3:0]  permanent_faulty_mult_i,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [31:0]      result_o,
  output logic [2:0]       error_detected_o,
  output logic [2:0]       mult_operator_o,
  output logic             no_majority_o,
  output logic             all_faulty_o,
  output logic [31:0]      vote_fail_cnt_o
);

  // cv32e40p_pkg multiplier operator encoding
  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_IR    = 3'b011;
  localparam logic [2:0] MUL_DOT8  = 3'b100;
  localparam logic [2:0] MUL_DOT16 = 3'b101;
  localparam logic [2:0] MUL_H     = 3'b110;

  // Last COLLECT cycle index: counter value seen on the timeout cycle
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [2:0]       elig_q;
  logic [2:0]       cap_q;
  logic [2:0][31:0] res_q;
  logic [7:0]       cnt_q;

  logic [31:0] result_q;
  logic [2:0]  err_q;
  logic [2:0]  op_out_q;
  logic        nomaj_q;
  logic        allf_q;

  logic [1:0]  op_class;
  logic        excl_en;
  logic [2:0]  elig_in;
  logic [2:0]  new_cap;
  logic        cap_all;
  logic        cnt_hit;

  logic [2:0]  voters;
  logic [31:0] vote_res;
  logic [2:0]  vote_err;
  logic        vote_nomaj;
  logic        eq01, eq02, eq12;

  // Map the issued operator to its fault class; unknown operators are never excluded
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_class = 2'd1;
    excl_en  = 1'b1;
    case (mult_operator_i)
      MUL_MAC32, MUL_MSU32:  op_class = 2'd0;
      MUL_I, MUL_IR, MUL_H:  op_class = 2'd1;
      MUL_DOT8:              op_class = 2'd2;
      MUL_DOT16:             op_class = 2'd3;
      default: begin
        op_class = 2'd1;
        excl_en  = 1'b0;
      end
    endcase
  end

  assign elig_in[0] = ~(excl_en & permanent_faulty_mult_i[0][op_class]);
  assign elig_in[1] = ~(excl_en & permanent_faulty_mult_i[1][op_class]);
  assign elig_in[2] = ~(excl_en & permanent_faulty_mult_i[2][op_class]);

  // First strobe of each eligible replica wins; later strobes are ignored
  assign new_cap = mult_valid_i & elig_q & ~cap_q;
  assign cap_all = ((cap_q | new_cap) == elig_q);
  assign cnt_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (elig_in == 3'b000) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (cap_all || cnt_hit) state_d = VOTE;
      end
      VOTE: state_d = DONE;
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Majority compare over the captured eligible replicas, plus missing-replica errors
  always_comb begin
    voters     = cap_q & elig_q;
    eq01       = (res_q[0] == res_q[1]);
    eq02       = (res_q[0] == res_q[2]);
    eq12       = (res_q[1] == res_q[2]);
    vote_res   = '0;
    vote_err   = 3'b000;
    vote_nomaj = 1'b0;
    case (voters)
      3'b111: begin
        if (eq01 && eq02) begin
          vote_res = res_q[0];
        end else if (eq01) begin
          vote_res = res_q[0];
          vote_err = 3'b100;
        end else if (eq02) begin
          vote_res = res_q[0];
          vote_err = 3'b010;
        end else if (eq12) begin
          vote_res = res_q[1];
          vote_err = 3'b001;
        end else begin
          vote_res   = res_q[0];
          vote_err   = 3'b111;
          vote_nomaj = 1'b1;
        end
      end
      3'b011: begin
        vote_res = res_q[0];
        if (!eq01) begin
          vote_err   = 3'b011;
          vote_nomaj = 1'b1;
        end
      end
      3'b101: begin
        vote_res = res_q[0];
        if (!eq02) begin
          vote_err   = 3'b101;
          vote_nomaj = 1'b1;
        end
      end
      3'b110: begin
        vote_res = res_q[1];
        if (!eq12) begin
          vote_err   = 3'b110;
          vote_nomaj = 1'b1;
        end
      end
      3'b001:  vote_res = res_q[0];
      3'b010:  vote_res = res_q[1];
      3'b100:  vote_res = res_q[2];
      default: vote_nomaj = 1'b1;
    endcase
    vote_err = vote_err | (elig_q & ~cap_q);
  end

  // Operation context, replica capture and registered vote outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the capture registers are reset as well, so a reset in mid-operation leaves no stale capture.
      op_q     <= MUL_MAC32;
      elig_q   <= 3'b000;
      cap_q    <= 3'b000;
      res_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 3'b000;
      op_out_q <= MUL_MAC32;
      nomaj_q  <= 1'b0;
      allf_q   <= 1'b0;
    end else begin
      err_q    <= 3'b000;
      op_out_q <= MUL_MAC32;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q   <= mult_operator_i;
            elig_q <= elig_in;
            cap_q  <= 3'b000;
            cnt_q  <= '0;
            if (elig_in == 3'b000) begin
              result_q <= mult_result_i[0];
              allf_q   <= 1'b1;
              nomaj_q  <= 1'b0;
            end
          end
        end
        COLLECT: begin
          cap_q <= cap_q | new_cap;
          cnt_q <= cnt_q + 8'd1;
          for (int r = 0; r < 3; r++) begin
            if (new_cap[r]) res_q[r] <= mult_result_i[r];
          end
        end
        VOTE: begin
          result_q <= vote_res;
          nomaj_q  <= vote_nomaj;
          allf_q   <= 1'b0;
          err_q    <= vote_err;
          op_out_q <= op_q;
        end
        DONE: begin
          if (out_ready_i) begin
            result_q <= '0;
            nomaj_q  <= 1'b0;
            allf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_VOTER_STATS_EN
  logic [31:0] fail_cnt_q;

  // Saturating count of no-majority votes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt_q <= '0;
    end else if ((state_q == VOTE) && vote_nomaj && (fail_cnt_q != 32'hFFFF_FFFF)) begin
      fail_cnt_q <= fail_cnt_q + 32'd1;
    end
  end

  assign vote_fail_cnt_o = fail_cnt_q;
`else
  assign vote_fail_cnt_o = '0;
`endif

  assign busy_o           = (state_q != IDLE);
  assign valid_o          = (state_q == DONE);
  assign result_o         = result_q;
  assign error_detected_o = err_q;
  assign mult_operator_o  = op_out_q;
  assign no_majority_o    = nomaj_q;
  assign all_faulty_o     = allf_q;

endmodule

// File: tb/tb_cv32e40p_mult_voter_ft.sv
// tb_cv32e40p_mult_voter_ft
// Directed vectors with hand-computed expectations for the MULT result voter.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at the
// same point, so they stay away from the active edge.

module tb_cv32e40p_mult_voter_ft;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_IR    = 3'b011;
  localparam logic [2:0] MUL_DOT8  = 3'b100;
  localparam logic [2:0] MUL_DOT16 = 3'b101;
  localparam logic [2:0] MUL_H     = 3'b110;
  localparam int NEVER = -1;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [2:0]       mult_operator_i;
  logic [2:0]       mult_valid_i;
  logic [2:0][31:0] mult_result_i;
  logic [2:0][3:0]  permanent_faulty_mult_i;
  logic             out_ready_i;
  logic             busy_o;
  logic             valid_o;
  logic [31:0]      result_o;
  logic [2:0]       error_detected_o;
  logic [2:0]       mult_operator_o;
  logic             no_majority_o;
  logic             all_faulty_o;
  logic [31:0]      vote_fail_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_mult_voter_ft #(.TIMEOUT_CYCLES(8)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start_i                 (start_i),
    .mult_operator_i         (mult_operator_i),
    .mult_valid_i            (mult_valid_i),
    .mult_result_i           (mult_result_i),
    .permanent_faulty_mult_i (permanent_faulty_mult_i),
    .out_ready_i             (out_ready_i),
    .busy_o                  (busy_o),
    .valid_o                 (valid_o),
    .result_o                (result_o),
    .error_detected_o        (error_detected_o),
    .mult_operator_o         (mult_operator_o),
    .no_majority_o           (no_majority_o),
    .all_faulty_o            (all_faulty_o),
    .vote_fail_cnt_o         (vote_fail_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, drive per-replica strobes at COLLECT cycle s*, then
  // check the DONE outputs, the one-cycle error pulse and the latency in cycles after start.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [11:0] pf,
                       input int s0, input int s1, input int s2,
                       input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] exp_res, input logic [2:0] exp_err,
                       input logic exp_nomaj, input logic exp_allf, input int exp_lat);
    int n;
    mult_operator_i         = op;
    permanent_faulty_mult_i = pf;
    mult_result_i[0]        = v0;
    mult_result_i[1]        = v1;
    mult_result_i[2]        = v2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin
      mult_valid_i = {(s2 == n), (s1 == n), (s0 == n)};
      tick();
      n++;
    end
    mult_valid_i = 3'b000;
    check({tag, "_valid"},   32'(valid_o), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"},  result_o, exp_res);
    check({tag, "_err"},     32'(error_detected_o), 32'(exp_err));
    check({tag, "_op"},      32'(mult_operator_o), 32'(exp_allf ? MUL_MAC32 : op));
    check({tag, "_nomaj"},   32'(no_majority_o), 32'(exp_nomaj));
    check({tag, "_allf"},    32'(all_faulty_o), 32'(exp_allf));
    tick();
    check({tag, "_err_pulse"}, 32'(error_detected_o), 32'd0);
    check({tag, "_op_pulse"},  32'(mult_operator_o), 32'(MUL_MAC32));
    check({tag, "_hold_v"},    32'(valid_o), 32'd1);
    check({tag, "_hold_r"},    result_o, exp_res);
  endtask

  task automatic accept(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_idle_busy"},  32'(busy_o), 32'd0);
    check({tag, "_idle_valid"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_cnt;
    rst_n                   = 1'b0;
    start_i                 = 1'b0;
    mult_operator_i         = MUL_MAC32;
    mult_valid_i            = 3'b000;
    mult_result_i           = '0;
    permanent_faulty_mult_i = '0;
    out_ready_i             = 1'b0;
    tick();
    tick();
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res",   result_o, 32'd0);
    check("rst_err",   32'(error_detected_o), 32'd0);
    check("rst_op",    32'(mult_operator_o), 32'(MUL_MAC32));
    check("rst_nomaj", 32'(no_majority_o), 32'd0);
    check("rst_allf",  32'(all_faulty_o), 32'd0);
    check("rst_cnt",   vote_fail_cnt_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // All agree, strobes two cycles after start; valid held until accepted
    do_op("mac32", MUL_MAC32, 12'h000, 1, 1, 1,
          32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
          32'h1234_5678, 3'b000, 1'b0, 1'b0, 3);
    tick();
    check("mac32_hold2", result_o, 32'h1234_5678);
    // A second start while DONE must be ignored
    mult_operator_i = MUL_DOT8;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_start_valid", 32'(valid_o), 32'd1);
    check("busy_start_res",   result_o, 32'h1234_5678);
    check("busy_start_op",    32'(mult_operator_o), 32'(MUL_MAC32));
    accept("mac32");

    // Reset in COLLECT with replica0 already captured
    mult_operator_i         = MUL_MAC32;
    permanent_faulty_mult_i = '0;
    mult_result_i           = {32'h0, 32'h0, 32'h0000_0111};
    start_i = 1'b1;
    tick();
    start_i      = 1'b0;
    mult_valid_i = 3'b001;
    tick();
    mult_valid_i = 3'b000;
    check("mid_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy",  32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    do_op("post_rst", MUL_MAC32, 12'h000, 3, 0, 0,
          32'h0000_0222, 32'h0000_0222, 32'h0000_0222,
          32'h0000_0222, 3'b000, 1'b0, 1'b0, 5);
    accept("post_rst");

    // Replica1 dissents
    do_op("dot8", MUL_DOT8, 12'h000, 0, 0, 0,
          32'h0000_BEEF, 32'hDEAD_0000, 32'h0000_BEEF,
          32'h0000_BEEF, 3'b010, 1'b0, 1'b0, 2);
    accept("dot8");

    // Replica2 excluded for DOT16; its strobe must not break the 5/6 tie
    do_op("dot16", MUL_DOT16, 12'h800, 0, 1, 0,
          32'd5, 32'd6, 32'd5,
          32'd5, 3'b011, 1'b1, 1'b0, 3);
    accept("dot16");

    // Replica0 never answers: vote on the eighth COLLECT cycle
    do_op("tmo", MUL_I, 12'h000, NEVER, 2, 2,
          32'hBAD0_BAD0, 32'd7, 32'd7,
          32'd7, 3'b001, 1'b0, 1'b0, 9);
    accept("tmo");

    // Every replica faulty for class0: straight to DONE
    do_op("allf", MUL_MSU32, 12'h111, 0, 0, 0,
          32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222,
          32'hCAFE_F00D, 3'b000, 1'b0, 1'b1, 0);
    accept("allf");

    // Three-way disagreement
    do_op("mulh", MUL_H, 12'h000, 0, 0, 0,
          32'd1, 32'd2, 32'd3,
          32'd1, 3'b111, 1'b1, 1'b0, 2);
    accept("mulh");

    // Nobody answers: zero voters
    do_op("none", MUL_IR, 12'h000, NEVER, NEVER, NEVER,
          32'd4, 32'd4, 32'd4,
          32'd0, 3'b111, 1'b1, 1'b0, 9);
    accept("none");

    // Unknown operator ignores the fault map entirely
    do_op("other", 3'b111, 12'hFFF, 0, 0, 0,
          32'd9, 32'd9, 32'd9,
          32'd9, 3'b000, 1'b0, 1'b0, 2);
    accept("other");

`ifdef MULT_VOTER_STATS_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check("vote_fail_cnt", vote_fail_cnt_o, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
